m_stack_param: RTL and testbench
================================

// Module: m_stack_param
// PURPOSE
//  Parametrised LIFO stack for the MPU datapath: next generation of the MPU stack.
//  Adds a registered top-of-stack view, simultaneous push+pop (replace-top), stack-pointer load
//  for context restore, an occupancy count and sticky overflow/underflow error flags.
//  Sits between the execute stage (push/pop/load) and the register file/PC (top-of-stack consumer).
// PARAMETERS
//  WORD   16  data width in bits (>=1)
//  DEPTH  4   number of entries (>=2); need not be a power of two
//  PW     $clog2(DEPTH+1)  localparam, width of pointer/count (holds 0..DEPTH)
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  reset      in   1     asynchronous, active-low reset
//  clear      in   1     synchronous flush: empties stack, clears error flags
//  load       in   1     load stack pointer from sp_i (context restore)
//  sp_i       in   PW    new occupancy for load
//  push       in   1     push data_i
//  pop        in   1     pop top entry
//  data_i     in   WORD  push data
//  data_o     out  WORD  current top-of-stack (registered); 0 when empty
//  count_o    out  PW    current occupancy (== stack pointer)
//  is_full    out  1     count_o == DEPTH
//  is_empty   out  1     count_o == 0
//  overflow   out  1     sticky: push attempted while full
//  underflow  out  1     sticky: pop attempted while empty, or load with sp_i > DEPTH
// BEHAVIOUR
//  Reset (async, reset==0): ptr=0, data_o=0, is_empty=1, is_full=0, overflow=0, underflow=0; memory contents not reset.
//  Storage: mem[0..DEPTH-1]; entry i valid for i < ptr; top is mem[ptr-1].
//  data_o is a register always equal to mem[ptr-1] (0 if ptr==0) after each edge; zero-latency top view.
//  Popped value = data_o sampled in the cycle pop is asserted (before the edge).
//  is_full/is_empty/count_o registered, consistent with ptr every cycle; no stale-flag cycles.
//  Priority per edge: clear > load > push/pop. Lower-priority requests in that cycle are dropped, no flags set.
//  clear: ptr<=0, data_o<=0, overflow<=0, underflow<=0.
//  load: if sp_i<=DEPTH: ptr<=sp_i, data_o<=mem[sp_i-1] (0 if sp_i==0); else ignore, underflow<=1.
//  push only: if !full: mem[ptr]<=data_i, ptr<=ptr+1, data_o<=data_i; if full: no change, overflow<=1.
//  pop only: if !empty: ptr<=ptr-1, data_o<=mem[ptr-2] (0 if ptr==1); if empty: no change, underflow<=1.
//  push+pop: if !empty: mem[ptr-1]<=data_i, data_o<=data_i, ptr unchanged (replace-top, legal when full).
//            if empty: behaves as push only; underflow not set.
//  No wrap-around: ptr saturates within 0..DEPTH; errors never corrupt contents.
//  Error flags hold until clear or reset; they do not block further operations.
//  Reset mid-operation: state returns to reset values immediately; in-flight push is lost.
// TESTING
//  Reset then idle -> data_o=0, count_o=0, is_empty=1, is_full=0, overflow=underflow=0.
//  DEPTH=4: push 0x11,0x22,0x33,0x44 -> data_o tracks 0x11..0x44, is_full=1 after 4th; 5th push 0x55 -> overflow=1, data_o=0x44, count 4.
//  From full: 4 pops -> data_o 0x33,0x22,0x11,0 in turn, is_empty=1; 5th pop -> underflow=1, count 0.
//  push 0xA,0xB then push+pop 0xC -> data_o=0xC, count 2; pop -> data_o=0xA; push+pop on empty 0xD -> count 1, data_o=0xD.
//  After 3 pushes, load sp_i=1 -> count 1, data_o=first pushed; load sp_i=5 -> ignored, underflow=1; clear -> count 0, flags 0.
//  Assert reset low mid push burst -> outputs at reset values before next clk edge; push after release lands at mem[0].

Source files
------------

// File: rtl/m_stack_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_stack_param : parametrised LIFO stack with registered top-of-stack view,
//                 replace-top, pointer load, occupancy and sticky error flags.
// Revision 1.0
// ----------------------------------------------------------------------------
module m_stack_param #(
  parameter int WORD  = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [PW-1:0]   sp_i,
  input  logic            push,
  input  logic            pop,
  input  logic [WORD-1:0] data_i,
  output logic [WORD-1:0] data_o,
  output logic [PW-1:0]   count_o,
  output logic            is_full,
  output logic            is_empty,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [PW-1:0] C_TWO   = PW'(2);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WORD-1:0] top_q, top_d;
  logic            full_q, empty_q;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            wr_en;
  logic [PW-1:0]   wr_addr;

  // Compare-based read so a non power-of-two DEPTH never indexes past the array.
  function automatic logic [WORD-1:0] rd(input logic [PW-1:0] idx);
    rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == PW'(i)) rd = mem_q[i];
    end
  endfunction

  always_comb begin
    ptr_d   = ptr_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    if (clear) begin
      ptr_d = '0;
      top_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (load) begin
      if (sp_i <= C_DEPTH) begin
        ptr_d = sp_i;
        top_d = (sp_i == '0) ? '0 : rd(sp_i - C_ONE);
      end else begin
        unf_d = 1'b1;
      end
    end else if (push && pop && !empty_q) begin
      wr_en   = 1'b1;
      wr_addr = ptr_q - C_ONE;
      top_d   = data_i;
    end else if (push) begin
      // Also covers push+pop on an empty stack.
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        ptr_d = ptr_q + C_ONE;
        top_d = data_i;
      end
    end else if (pop) begin
      if (empty_q) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - C_ONE;
        top_d = (ptr_q == C_ONE) ? '0 : rd(ptr_q - C_TWO);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      top_q   <= top_d;
      full_q  <= (ptr_d == C_DEPTH);
      empty_q <= (ptr_d == '0);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset && wr_en && (wr_addr == PW'(i))) mem_q[i] <= data_i;
    end
  end

  assign data_o    = top_q;
  assign count_o   = ptr_q;
  assign is_full   = full_q;
  assign is_empty  = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_m_stack_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_m_stack_param : directed bench with a behavioural LIFO model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_m_stack_param;

  localparam int WORD  = 16;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic            load = 1'b0;
  logic [PW-1:0]   sp_i = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic [WORD-1:0] data_i = '0;
  logic [WORD-1:0] data_o;
  logic [PW-1:0]   count_o;
  logic            is_full, is_empty, overflow, underflow;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  m_stack_param #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .sp_i(sp_i),
    .push(push), .pop(pop), .data_i(data_i), .data_o(data_o),
    .count_o(count_o), .is_full(is_full), .is_empty(is_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a list of stored words plus an occupancy; top is simply the last live entry.
  int              m_cnt = 0;
  bit              m_ovf = 0, m_unf = 0;
  logic [WORD-1:0] m_mem [DEPTH];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (clear) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (load) begin
      if (int'(sp_i) <= DEPTH) m_cnt = int'(sp_i);
      else m_unf = 1;
    end else if (push && pop && m_cnt > 0) begin
      m_mem[m_cnt-1] = data_i;
    end else if (push) begin
      if (m_cnt == DEPTH) m_ovf = 1;
      else begin m_mem[m_cnt] = data_i; m_cnt++; end
    end else if (pop) begin
      if (m_cnt == 0) m_unf = 1;
      else m_cnt--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc data_o",    32'(data_o),    (m_cnt == 0) ? 32'h0 : 32'(m_mem[m_cnt-1]));
      chk("cyc count_o",   32'(count_o),   32'(m_cnt));
      chk("cyc is_full",   32'(is_full),   32'(m_cnt == DEPTH));
      chk("cyc is_empty",  32'(is_empty),  32'(m_cnt == 0));
      chk("cyc overflow",  32'(overflow),  32'(m_ovf));
      chk("cyc underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // One clocked operation; inputs return to idle 1ns after the edge.
  task automatic op(input bit c, input bit l, input int sp, input bit ps, input bit pp,
                    input logic [WORD-1:0] d);
    clear = c; load = l; sp_i = PW'(sp); push = ps; pop = pp; data_i = d;
    @(posedge clk); #1;
    clear = 0; load = 0; push = 0; pop = 0;
  endtask

  task automatic chk_state(input string name, input logic [WORD-1:0] d, input int cnt,
                           input bit ovf, input bit unf);
    chk({name, " data"},  32'(data_o),    32'(d));
    chk({name, " count"}, 32'(count_o),   32'(cnt));
    chk({name, " ovf"},   32'(overflow),  32'(ovf));
    chk({name, " unf"},   32'(underflow), 32'(unf));
  endtask

  logic [WORD-1:0] pat [4];

  initial begin
    pat[0] = 16'h11; pat[1] = 16'h22; pat[2] = 16'h33; pat[3] = 16'h44;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk_state("reset", 16'h0, 0, 0, 0);
    chk("reset empty", 32'(is_empty), 32'd1);
    chk("reset full",  32'(is_full),  32'd0);

    for (int i = 0; i < 4; i++) begin
      op(0, 0, 0, 1, 0, pat[i]);
      chk("push top", 32'(data_o), 32'(pat[i]));
    end
    chk("full after 4", 32'(is_full), 32'd1);
    op(0, 0, 0, 1, 0, 16'h55);
    chk_state("push on full", 16'h44, 4, 1, 0);

    for (int i = 2; i >= -1; i--) begin
      op(0, 0, 0, 0, 1, 16'h0);
      chk("pop top", 32'(data_o), (i >= 0) ? 32'(pat[i]) : 32'h0);
    end
    chk("empty after pops", 32'(is_empty), 32'd1);
    op(0, 0, 0, 0, 1, 16'h0);
    chk_state("pop on empty", 16'h0, 0, 1, 1);

    op(1, 0, 0, 0, 0, 16'h0);
    chk_state("clear", 16'h0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 16'hA);
    op(0, 0, 0, 1, 0, 16'hB);
    op(0, 0, 0, 1, 1, 16'hC);
    chk_state("replace top", 16'hC, 2, 0, 0);
    op(0, 0, 0, 0, 1, 16'h0);
    chk_state("pop after replace", 16'hA, 1, 0, 0);
    op(0, 0, 0, 0, 1, 16'h0);
    op(0, 0, 0, 1, 1, 16'hD);
    chk_state("push+pop empty", 16'hD, 1, 0, 0);

    op(1, 0, 0, 0, 0, 16'h0);
    op(0, 0, 0, 1, 0, 16'h101);
    op(0, 0, 0, 1, 0, 16'h202);
    op(0, 0, 0, 1, 0, 16'h303);
    op(0, 1, 1, 1, 0, 16'h999);
    chk_state("load 1", 16'h101, 1, 0, 0);
    op(0, 1, 3, 0, 0, 16'h0);
    chk_state("load 3 restore", 16'h303, 3, 0, 0);
    op(0, 1, 5, 0, 0, 16'h0);
    chk_state("load 5 ignored", 16'h303, 3, 0, 1);
    op(0, 1, 0, 0, 0, 16'h0);
    chk_state("load 0", 16'h0, 0, 0, 1);
    op(1, 1, 2, 1, 0, 16'h777);
    chk_state("clear priority", 16'h0, 0, 0, 0);

    op(0, 0, 0, 1, 0, 16'h61);
    op(0, 0, 0, 1, 0, 16'h62);
    push = 1; data_i = 16'h63;
    #2 reset = 1'b0;
    #1;
    chk_state("async reset", 16'h0, 0, 0, 0);
    chk("async reset empty", 32'(is_empty), 32'd1);
    @(posedge clk); #1;
    push = 0;
    reset = 1'b1;
    op(0, 0, 0, 1, 0, 16'h77);
    chk_state("push after reset", 16'h77, 1, 0, 0);
    op(0, 0, 0, 0, 1, 16'h0);
    chk_state("pop after reset", 16'h0, 0, 0, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
